// File: rtl/axi_sync_fifo_param_if.sv
// rtl/axi_sync_fifo_param_if.sv - control, data and status bundle for the parametrised sync FIFO
interface axi_sync_fifo_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic              flush;
    logic              wpush;
    logic [DATA_W-1:0] wdata;
    logic              rpop;
    logic              err_clr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wpush, wdata, rpop, err_clr,
        input  rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, wpush, wdata, rpop, err_clr,
        output rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/axi_sync_fifo_param.sv
// rtl/axi_sync_fifo_param.sv - single-clock FIFO with FWFT/registered read, almost flags and sticky errors
module axi_sync_fifo_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 2,
    parameter int FWFT     = 1,
    parameter int AF_LEVEL = (1 << ADDR_W) - 1,
    parameter int AE_LEVEL = 1
) (
    input logic                  ACLK,
    input logic                  ARESETn,
    axi_sync_fifo_param_if.slave bus
);
    localparam int             DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AF_TH = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_TH = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W:0]   cnt;
    logic              empty_i;
    logic              full_i;
    logic              push_ok;
    logic              pop_ok;
    logic              overflow_q;
    logic              underflow_q;

    // Flags come only from registered pointers, so push/pop never reach them combinationally.
    assign empty_i = (wptr == rptr);
    assign full_i  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
    assign push_ok = bus.wpush && !full_i && !bus.flush;
    assign pop_ok  = bus.rpop && !empty_i && !bus.flush;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (bus.flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= wptr + ONE;
            if (pop_ok)  rptr <= rptr + ONE;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + ONE;
                2'b01:   cnt <= cnt - ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // A new error event beats a same-cycle clear; flush suppresses error detection.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wpush && full_i && !bus.flush) overflow_q <= 1'b1;
            else if (bus.err_clr)                  overflow_q <= 1'b0;
            if (bus.rpop && empty_i && !bus.flush) underflow_q <= 1'b1;
            else if (bus.err_clr)                  underflow_q <= 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_ok) mem[wptr[ADDR_W-1:0]] <= bus.wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rdata  = mem[rptr[ADDR_W-1:0]];
            assign bus.rvalid = !empty_i;
        end else begin : g_reg
            logic [DATA_W-1:0] rdata_q;
            logic              rvalid_q;

            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= pop_ok;
                    if (pop_ok) rdata_q <= mem[rptr[ADDR_W-1:0]];
                end
            end

            assign bus.rdata  = rdata_q;
            assign bus.rvalid = rvalid_q;
        end
    endgenerate

    assign bus.count        = cnt;
    assign bus.empty        = empty_i;
    assign bus.full         = full_i;
    assign bus.almost_full  = (cnt >= AF_TH);
    assign bus.almost_empty = (cnt <= AE_TH);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/axi_sync_fifo_param.md
# axi_sync_fifo_param

Parametrised single-clock FIFO that generalises the AXI channel buffer memories (fixed width/depth, write port only, flags computed elsewhere) into one self-contained block. It owns storage, pointers, occupancy count, full/empty and programmable almost-flags, sticky overflow/underflow error flags, synchronous flush, and a selectable read mode: first-word-fall-through or registered read. Used for same-clock AXI channel buffering (AR/R/AW/W/B) between masters, the bridge and slaves where CDC is not required.

## Interface
- DATA_W, 32: payload width in bits (≥1).
- ADDR_W, 2: log2 of depth; DEPTH = 2^ADDR_W (ADDR_W ≥ 1).
- FWFT, 1: 1 = first-word-fall-through read; 0 = registered read, data one cycle after pop.
- AF_LEVEL, DEPTH-1: almost_full asserted when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserted when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- ACLK  input  1  clock; all state updates on rising edge.
- ARESETn  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of pointers/count/rvalid.
- wpush  input  1  write request.
- wdata  input  DATA_W  write payload.
- rpop  input  1  read request.
- rdata  output  DATA_W  read payload.
- rvalid  output  1  FWFT=1: equals !empty; FWFT=0: one-cycle pulse when rdata holds newly popped word.
- full, empty  output  1 each  occupancy flags.
- almost_full, almost_empty  output  1 each  threshold flags.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- err_clr  input  1  clears sticky error flags.
- overflow, underflow  output  1 each  sticky error flags.

## Operation
- Pointers wptr/rptr are ADDR_W+1 bits; low ADDR_W bits index memory, MSB is the wrap bit. empty = (wptr == rptr); full = low bits equal and MSBs differ. Pointers wrap naturally modulo 2^(ADDR_W+1).
- Push accepted iff wpush && !full (evaluated on flags at that cycle, before any same-cycle pop). Accepted push writes mem[wptr] and increments wptr.
- Pop accepted iff rpop && !empty (flags at that cycle). Accepted pop increments rptr.
- Simultaneous push+pop: at full, pop accepted, push rejected (overflow set); at empty, push accepted, pop rejected (underflow set); otherwise both accepted, count unchanged.
- count: +1 on push-only, −1 on pop-only, unchanged otherwise; registered, never exceeds DEPTH or goes below 0.
- Flags full/empty/almost_* derived from registered count/pointers; no combinational path from wpush/rpop to any flag.
- FWFT=1: rdata = mem[rptr low bits] combinationally; content is don't-care while empty.
- FWFT=0: on accepted pop, rdata register loads mem[rptr] and rvalid pulses high for exactly one cycle; otherwise rdata holds and rvalid = 0.
- overflow set on wpush && full; underflow set on rpop && empty; both cleared by err_clr; set wins over simultaneous err_clr.
- flush: wptr, rptr, count ← 0, rvalid ← 0; dominant over push/pop in the same cycle (neither accepted, no error set); error flags and rdata register unaffected; memory contents not cleared.
- Memory array is not reset.

## Timing
- Reset (ARESETn low, asynchronous): wptr = rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = underflow = 0, rvalid = 0, registered rdata = 0 (FWFT=0).
- Push at edge N: count/flags updated after edge N; FWFT=1 data visible on rdata after edge N when FIFO was empty (write-to-read latency 1 cycle).
- FWFT=0 pop at edge N: rdata/rvalid valid after edge N (1-cycle read latency).
- ARESETn deassertion is synchronised externally; block samples first push on the first edge with ARESETn high.
- Reset mid-transfer discards all contents; empty asserted immediately on ARESETn low.

## Test plan
- DATA_W=32, ADDR_W=2, FWFT=1: push 0xA0..0xA3 → full=1, count=4 after 4th edge; 5th push → overflow=1, count stays 4; pop 4 → rdata 0xA0,0xA1,0xA2,0xA3 in order, empty=1.
- Wrap-around: 10 interleaved push/pop cycles of 3-deep occupancy with DEPTH=4 → data order preserved across pointer MSB wrap, count never >4.
- Simultaneous push+pop at count 2 → count stays 2; at full → overflow=1, one word out; at empty → underflow=1, count=1.
- FWFT=0: push 0x11,0x22; pop at edge N → rdata=0x11, rvalid=1 only for cycle after N; rvalid=0 while idle.
- AF_LEVEL=3, AE_LEVEL=1: count 0→4 → almost_empty high at 0,1; almost_full high at 3,4; err_clr with concurrent overflow → overflow stays 1.
- Flush at count 3 with concurrent push → count=0, empty=1, no overflow; ARESETn low mid-fill → all outputs at reset values same cycle.
